// File: rtl/prl_rx_pkg.sv
// Shared constants and types for the USB PD protocol-layer receive engine.
// Holds the FSM encoding, frame-type codes, message limits and the MessageID slot mapping.
package prl_rx_pkg;

  localparam int MAX_BYTES  = 30;
  localparam int DATA_BYTES = MAX_BYTES - 2;

  localparam logic [4:0] GOODCRC_MSGTYPE = 5'b00001;

  localparam logic [2:0] FT_SOP          = 3'd0;
  localparam logic [2:0] FT_SOP_P        = 3'd1;
  localparam logic [2:0] FT_SOP_PP       = 3'd2;
  localparam logic [2:0] FT_SOP_DBG_P    = 3'd3;
  localparam logic [2:0] FT_SOP_DBG_PP   = 3'd4;
  localparam logic [2:0] FT_HARD_RESET   = 3'd6;

  typedef enum logic [2:0] {
    ST_WAIT_SOP     = 3'd0,
    ST_RECEIVE      = 3'd1,
    ST_CHECK        = 3'd2,
    ST_STORE        = 3'd3,
    ST_SEND_GOODCRC = 3'd4
  } state_e;

  // SOP' and SOP'' own a slot each; every other SOP-family type shares slot 0.
  function automatic logic [1:0] msgid_slot(input logic [2:0] frame_type);
    case (frame_type)
      FT_SOP_P:  msgid_slot = 2'd1;
      FT_SOP_PP: msgid_slot = 2'd2;
      default:   msgid_slot = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/prl_rx_msgid_table.sv
// Last-accepted MessageID per SOP slot, each with a valid bit.
// Lookup is combinational; update and clear take effect on the next clock edge.
module prl_rx_msgid_table
  import prl_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic [2:0] lookup_type_i,
  output logic [2:0] lookup_id_o,
  output logic       lookup_valid_o,
  input  logic       update_i,
  input  logic [2:0] update_type_i,
  input  logic [2:0] update_id_i
);

  logic [2:0] id_q [3];
  logic [2:0] valid_q;
  logic [1:0] lookup_slot;
  logic [1:0] update_slot;

  assign lookup_slot    = msgid_slot(lookup_type_i);
  assign update_slot    = msgid_slot(update_type_i);
  assign lookup_id_o    = id_q[lookup_slot];
  assign lookup_valid_o = valid_q[lookup_slot];

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) id_q[i] <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 3; i++) id_q[i] <= '0;
      valid_q <= '0;
    end else if (update_i) begin
      id_q[update_slot]    <= update_id_i;
      valid_q[update_slot] <= 1'b1;
    end
  end

endmodule

// File: rtl/prl_rx.sv
// USB PD protocol-layer receive engine: frames PHY bytes, validates length,
// CRC and MessageID, publishes accepted messages and requests GoodCRC replies.
module prl_rx
  import prl_rx_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PHY_RX_SOP,
  input  logic [2:0]              PHY_RX_FRAME_TYPE,
  input  logic                    PHY_RX_VALID,
  input  logic [7:0]              PHY_RX_DATA,
  input  logic                    PHY_RX_EOP,
  input  logic                    PHY_RX_CRC_OK,
  input  logic                    ALERT_CLEAR,
  input  logic                    TX_GOODCRC_ACK,
  output logic [7:0]              RX_BUF_FRAME_TYPE,
  output logic [7:0]              RX_BUF_HEADER_BYTE_0,
  output logic [7:0]              RX_BUF_HEADER_BYTE_1,
  output logic [7:0]              RX_BUF_BYTE_COUNT,
  output logic [8*DATA_BYTES-1:0] RX_BUF_DATA_OBJECTS,
  output logic                    GoodCRC_Response,
  output logic                    TX_GOODCRC_REQUEST,
  output logic [2:0]              TX_GOODCRC_FRAME_TYPE,
  output logic                    ALERT_ReceivedSOP_MessageStatus,
  output logic                    ALERT_ReceivedHardReset
);

  state_e     state_q;
  logic [2:0] frame_type_q;
  logic [7:0] stage_q [MAX_BYTES];
  logic [7:0] count_q;
  logic       overflow_q;
  logic       crc_ok_q;
  logic       is_goodcrc_q;

  logic [2:0] ndo;
  logic [2:0] msg_id;
  logic       is_goodcrc;
  logic       len_ok;
  logic       hard_reset_seen;
  logic       sop_seen;
  logic [2:0] stored_id;
  logic       stored_valid;
  logic       duplicate;

  assign ndo        = stage_q[1][6:4];
  assign msg_id     = stage_q[1][3:1];
  assign is_goodcrc = (stage_q[0][4:0] == GOODCRC_MSGTYPE) && (ndo == 3'd0);
  assign len_ok     = (count_q >= 8'd2) && (count_q == ({3'b000, ndo, 2'b00} + 8'd2));
  assign duplicate  = stored_valid && (stored_id == msg_id);

  // PHY framing is only observed while idle or mid-frame.
  assign hard_reset_seen = PHY_RX_SOP && (PHY_RX_FRAME_TYPE == FT_HARD_RESET) &&
                           (state_q == ST_WAIT_SOP || state_q == ST_RECEIVE);
  assign sop_seen        = PHY_RX_SOP && (PHY_RX_FRAME_TYPE <= FT_SOP_DBG_PP) &&
                           (state_q == ST_WAIT_SOP || state_q == ST_RECEIVE);

  prl_rx_msgid_table u_msgid_table (
    .clk            (CLK),
    .rst            (RESET),
    .clear_i        (hard_reset_seen),
    .lookup_type_i  (frame_type_q),
    .lookup_id_o    (stored_id),
    .lookup_valid_o (stored_valid),
    .update_i       ((state_q == ST_STORE) && !is_goodcrc_q),
    .update_type_i  (frame_type_q),
    .update_id_i    (msg_id)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q                         <= ST_WAIT_SOP;
      frame_type_q                    <= '0;
      // NOTE: the staging array is reset so a short frame never exposes stale bytes.
      for (int i = 0; i < MAX_BYTES; i++) stage_q[i] <= '0;
      count_q                         <= '0;
      overflow_q                      <= 1'b0;
      crc_ok_q                        <= 1'b0;
      is_goodcrc_q                    <= 1'b0;
      RX_BUF_FRAME_TYPE               <= '0;
      RX_BUF_HEADER_BYTE_0            <= '0;
      RX_BUF_HEADER_BYTE_1            <= '0;
      RX_BUF_BYTE_COUNT               <= '0;
      RX_BUF_DATA_OBJECTS             <= '0;
      GoodCRC_Response                <= 1'b0;
      TX_GOODCRC_REQUEST              <= 1'b0;
      TX_GOODCRC_FRAME_TYPE           <= '0;
      ALERT_ReceivedSOP_MessageStatus <= 1'b0;
      ALERT_ReceivedHardReset         <= 1'b0;
    end else begin
      GoodCRC_Response        <= 1'b0;
      ALERT_ReceivedHardReset <= 1'b0;
      if (ALERT_CLEAR) ALERT_ReceivedSOP_MessageStatus <= 1'b0;

      if (hard_reset_seen) begin
        ALERT_ReceivedHardReset <= 1'b1;
        state_q                 <= ST_WAIT_SOP;
      end else if (sop_seen) begin
        frame_type_q <= PHY_RX_FRAME_TYPE;
        for (int i = 0; i < MAX_BYTES; i++) stage_q[i] <= '0;
        count_q      <= '0;
        overflow_q   <= 1'b0;
        state_q      <= ST_RECEIVE;
      end else begin
        case (state_q)
          ST_RECEIVE: begin
            if (PHY_RX_VALID) begin
              if (count_q < 8'(MAX_BYTES)) begin
                stage_q[count_q[4:0]] <= PHY_RX_DATA;
                count_q               <= count_q + 8'd1;
              end else begin
                overflow_q <= 1'b1;
              end
            end
            if (PHY_RX_EOP) begin
              crc_ok_q <= PHY_RX_CRC_OK;
              state_q  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            is_goodcrc_q <= is_goodcrc;
            if (!crc_ok_q || overflow_q || !len_ok) begin
              state_q <= ST_WAIT_SOP;
            end else if (is_goodcrc) begin
              state_q <= ST_STORE;
            end else if (ALERT_ReceivedSOP_MessageStatus) begin
              state_q <= ST_WAIT_SOP;
            end else if (duplicate) begin
              TX_GOODCRC_REQUEST    <= 1'b1;
              TX_GOODCRC_FRAME_TYPE <= frame_type_q;
              state_q               <= ST_SEND_GOODCRC;
            end else begin
              state_q <= ST_STORE;
            end
          end
          ST_STORE: begin
            RX_BUF_FRAME_TYPE    <= {5'b00000, frame_type_q};
            RX_BUF_HEADER_BYTE_0 <= stage_q[0];
            RX_BUF_HEADER_BYTE_1 <= stage_q[1];
            RX_BUF_BYTE_COUNT    <= count_q;
            for (int k = 0; k < DATA_BYTES; k++) RX_BUF_DATA_OBJECTS[8*k +: 8] <= stage_q[k+2];
            if (is_goodcrc_q) begin
              GoodCRC_Response <= 1'b1;
              state_q          <= ST_WAIT_SOP;
            end else begin
              // Written after the clear above so a coincident ALERT_CLEAR loses.
              ALERT_ReceivedSOP_MessageStatus <= 1'b1;
              TX_GOODCRC_REQUEST              <= 1'b1;
              TX_GOODCRC_FRAME_TYPE           <= frame_type_q;
              state_q                         <= ST_SEND_GOODCRC;
            end
          end
          ST_SEND_GOODCRC: begin
            if (TX_GOODCRC_ACK) begin
              TX_GOODCRC_REQUEST <= 1'b0;
              state_q            <= ST_WAIT_SOP;
            end
          end
          default: state_q <= ST_WAIT_SOP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prl_rx.sv
// Directed self-checking bench for prl_rx: one task per scenario, expected
// values computed by hand from the message headers and data bytes.
module tb_prl_rx;

  typedef logic [7:0] byte_q_t [$];

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         PHY_RX_SOP = 1'b0;
  logic [2:0]   PHY_RX_FRAME_TYPE = '0;
  logic         PHY_RX_VALID = 1'b0;
  logic [7:0]   PHY_RX_DATA = '0;
  logic         PHY_RX_EOP = 1'b0;
  logic         PHY_RX_CRC_OK = 1'b0;
  logic         ALERT_CLEAR = 1'b0;
  logic         TX_GOODCRC_ACK = 1'b0;
  logic [7:0]   RX_BUF_FRAME_TYPE;
  logic [7:0]   RX_BUF_HEADER_BYTE_0;
  logic [7:0]   RX_BUF_HEADER_BYTE_1;
  logic [7:0]   RX_BUF_BYTE_COUNT;
  logic [223:0] RX_BUF_DATA_OBJECTS;
  logic         GoodCRC_Response;
  logic         TX_GOODCRC_REQUEST;
  logic [2:0]   TX_GOODCRC_FRAME_TYPE;
  logic         ALERT_ReceivedSOP_MessageStatus;
  logic         ALERT_ReceivedHardReset;

  int n_checks = 0;
  int n_fail   = 0;
  byte_q_t fr;

  prl_rx dut (
    .CLK                             (CLK),
    .RESET                           (RESET),
    .PHY_RX_SOP                      (PHY_RX_SOP),
    .PHY_RX_FRAME_TYPE               (PHY_RX_FRAME_TYPE),
    .PHY_RX_VALID                    (PHY_RX_VALID),
    .PHY_RX_DATA                     (PHY_RX_DATA),
    .PHY_RX_EOP                      (PHY_RX_EOP),
    .PHY_RX_CRC_OK                   (PHY_RX_CRC_OK),
    .ALERT_CLEAR                     (ALERT_CLEAR),
    .TX_GOODCRC_ACK                  (TX_GOODCRC_ACK),
    .RX_BUF_FRAME_TYPE               (RX_BUF_FRAME_TYPE),
    .RX_BUF_HEADER_BYTE_0            (RX_BUF_HEADER_BYTE_0),
    .RX_BUF_HEADER_BYTE_1            (RX_BUF_HEADER_BYTE_1),
    .RX_BUF_BYTE_COUNT               (RX_BUF_BYTE_COUNT),
    .RX_BUF_DATA_OBJECTS             (RX_BUF_DATA_OBJECTS),
    .GoodCRC_Response                (GoodCRC_Response),
    .TX_GOODCRC_REQUEST              (TX_GOODCRC_REQUEST),
    .TX_GOODCRC_FRAME_TYPE           (TX_GOODCRC_FRAME_TYPE),
    .ALERT_ReceivedSOP_MessageStatus (ALERT_ReceivedSOP_MessageStatus),
    .ALERT_ReceivedHardReset         (ALERT_ReceivedHardReset)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns one unit after the edge that samples EOP (FSM then in CHECK).
  task automatic send_frame(input logic [2:0] ft, input byte_q_t b, input logic crc);
    PHY_RX_SOP        = 1'b1;
    PHY_RX_FRAME_TYPE = ft;
    tick();
    PHY_RX_SOP = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      PHY_RX_VALID  = 1'b1;
      PHY_RX_DATA   = b[i];
      PHY_RX_EOP    = (i == b.size() - 1);
      PHY_RX_CRC_OK = crc && (i == b.size() - 1);
      tick();
    end
    PHY_RX_VALID  = 1'b0;
    PHY_RX_DATA   = '0;
    PHY_RX_EOP    = 1'b0;
    PHY_RX_CRC_OK = 1'b0;
  endtask

  task automatic pulse_ack();
    TX_GOODCRC_ACK = 1'b1;
    tick();
    TX_GOODCRC_ACK = 1'b0;
  endtask

  task automatic pulse_alert_clear();
    ALERT_CLEAR = 1'b1;
    tick();
    ALERT_CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    ticks(2);
    n_checks++;
    if (RX_BUF_BYTE_COUNT !== 8'h00) begin
      n_fail++; $display("FAIL reset_count: got %h expected 00", RX_BUF_BYTE_COUNT);
    end
    n_checks++;
    if (RX_BUF_DATA_OBJECTS !== 224'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", RX_BUF_DATA_OBJECTS);
    end
    n_checks++;
    if ({GoodCRC_Response, TX_GOODCRC_REQUEST, ALERT_ReceivedSOP_MessageStatus,
         ALERT_ReceivedHardReset, TX_GOODCRC_FRAME_TYPE, RX_BUF_FRAME_TYPE,
         RX_BUF_HEADER_BYTE_0, RX_BUF_HEADER_BYTE_1} !== 31'd0) begin
      n_fail++; $display("FAIL reset_flags: got nonzero control/header outputs expected 0");
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_goodcrc();
    fr = '{8'h41, 8'h00};
    send_frame(3'd0, fr, 1'b1);
    tick();
    n_checks++;
    if (GoodCRC_Response !== 1'b0) begin
      n_fail++; $display("FAIL goodcrc_early: got %b expected 0", GoodCRC_Response);
    end
    tick();
    n_checks++;
    if (GoodCRC_Response !== 1'b1) begin
      n_fail++; $display("FAIL goodcrc_pulse: got %b expected 1", GoodCRC_Response);
    end
    n_checks++;
    if ({RX_BUF_HEADER_BYTE_0, RX_BUF_HEADER_BYTE_1, RX_BUF_BYTE_COUNT} !== 24'h410002) begin
      n_fail++; $display("FAIL goodcrc_buf: got %h%h%h expected 410002",
                         RX_BUF_HEADER_BYTE_0, RX_BUF_HEADER_BYTE_1, RX_BUF_BYTE_COUNT);
    end
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b0 || ALERT_ReceivedSOP_MessageStatus !== 1'b0) begin
      n_fail++; $display("FAIL goodcrc_noreq: got req=%b alert=%b expected 0 0",
                         TX_GOODCRC_REQUEST, ALERT_ReceivedSOP_MessageStatus);
    end
    tick();
    n_checks++;
    if (GoodCRC_Response !== 1'b0) begin
      n_fail++; $display("FAIL goodcrc_pulse_end: got %b expected 0", GoodCRC_Response);
    end
  endtask

  task automatic test_data_msg();
    fr = '{8'h43, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(3'd0, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (RX_BUF_BYTE_COUNT !== 8'd6) begin
      n_fail++; $display("FAIL data_count: got %0d expected 6", RX_BUF_BYTE_COUNT);
    end
    n_checks++;
    if (RX_BUF_DATA_OBJECTS[31:0] !== 32'hDDCCBBAA || RX_BUF_DATA_OBJECTS[223:32] !== '0) begin
      n_fail++; $display("FAIL data_objects: got %h expected ddccbbaa", RX_BUF_DATA_OBJECTS);
    end
    n_checks++;
    if (ALERT_ReceivedSOP_MessageStatus !== 1'b1 || GoodCRC_Response !== 1'b0) begin
      n_fail++; $display("FAIL data_alert: got alert=%b gcr=%b expected 1 0",
                         ALERT_ReceivedSOP_MessageStatus, GoodCRC_Response);
    end
    ticks(3);
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b1 || TX_GOODCRC_FRAME_TYPE !== 3'd0) begin
      n_fail++; $display("FAIL data_req_hold: got req=%b ft=%0d expected 1 0",
                         TX_GOODCRC_REQUEST, TX_GOODCRC_FRAME_TYPE);
    end
    pulse_ack();
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b0) begin
      n_fail++; $display("FAIL data_req_ack: got %b expected 0", TX_GOODCRC_REQUEST);
    end
  endtask

  task automatic test_duplicate();
    pulse_alert_clear();
    n_checks++;
    if (ALERT_ReceivedSOP_MessageStatus !== 1'b0) begin
      n_fail++; $display("FAIL alert_clear: got %b expected 0", ALERT_ReceivedSOP_MessageStatus);
    end
    fr = '{8'h43, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(3'd0, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b1 || ALERT_ReceivedSOP_MessageStatus !== 1'b0) begin
      n_fail++; $display("FAIL dup_req: got req=%b alert=%b expected 1 0",
                         TX_GOODCRC_REQUEST, ALERT_ReceivedSOP_MessageStatus);
    end
    n_checks++;
    if (RX_BUF_DATA_OBJECTS[31:0] !== 32'hDDCCBBAA) begin
      n_fail++; $display("FAIL dup_buf: got %h expected ddccbbaa", RX_BUF_DATA_OBJECTS[31:0]);
    end
    pulse_ack();
  endtask

  task automatic test_discard();
    fr = '{8'h43, 8'h14, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(3'd0, fr, 1'b0);
    ticks(3);
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b0 || ALERT_ReceivedSOP_MessageStatus !== 1'b0 ||
        RX_BUF_DATA_OBJECTS[31:0] !== 32'hDDCCBBAA) begin
      n_fail++; $display("FAIL bad_crc: got req=%b alert=%b data=%h expected 0 0 ddccbbaa",
                         TX_GOODCRC_REQUEST, ALERT_ReceivedSOP_MessageStatus,
                         RX_BUF_DATA_OBJECTS[31:0]);
    end
    // NDO 7 makes 30 the matching length, so only the 31st byte can cause the drop.
    fr = '{8'h43, 8'h7A};
    for (int i = 0; i < 29; i++) fr.push_back(8'(8'h50 + i));
    send_frame(3'd0, fr, 1'b1);
    ticks(3);
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b0 || ALERT_ReceivedSOP_MessageStatus !== 1'b0 ||
        RX_BUF_BYTE_COUNT !== 8'd6 || RX_BUF_HEADER_BYTE_1 !== 8'h12) begin
      n_fail++; $display("FAIL overflow: got req=%b alert=%b cnt=%0d h1=%h expected 0 0 6 12",
                         TX_GOODCRC_REQUEST, ALERT_ReceivedSOP_MessageStatus,
                         RX_BUF_BYTE_COUNT, RX_BUF_HEADER_BYTE_1);
    end
    fr = '{8'h41, 8'h00};
    send_frame(3'd0, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (GoodCRC_Response !== 1'b1 || RX_BUF_BYTE_COUNT !== 8'd2) begin
      n_fail++; $display("FAIL back_to_idle: got gcr=%b cnt=%0d expected 1 2",
                         GoodCRC_Response, RX_BUF_BYTE_COUNT);
    end
    tick();
  endtask

  task automatic test_alert_busy();
    fr = '{8'h43, 8'h14, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(3'd0, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (ALERT_ReceivedSOP_MessageStatus !== 1'b1 || RX_BUF_DATA_OBJECTS[31:0] !== 32'h04030201) begin
      n_fail++; $display("FAIL id2_accept: got alert=%b data=%h expected 1 04030201",
                         ALERT_ReceivedSOP_MessageStatus, RX_BUF_DATA_OBJECTS[31:0]);
    end
    pulse_ack();
    fr = '{8'h43, 8'h16, 8'h09, 8'h09, 8'h09, 8'h09};
    send_frame(3'd0, fr, 1'b1);
    ticks(3);
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b0 || RX_BUF_DATA_OBJECTS[31:0] !== 32'h04030201 ||
        RX_BUF_HEADER_BYTE_1 !== 8'h14) begin
      n_fail++; $display("FAIL busy_discard: got req=%b data=%h h1=%h expected 0 04030201 14",
                         TX_GOODCRC_REQUEST, RX_BUF_DATA_OBJECTS[31:0], RX_BUF_HEADER_BYTE_1);
    end
  endtask

  task automatic test_hard_reset();
    pulse_alert_clear();
    PHY_RX_SOP        = 1'b1;
    PHY_RX_FRAME_TYPE = 3'd6;
    tick();
    PHY_RX_SOP = 1'b0;
    n_checks++;
    if (ALERT_ReceivedHardReset !== 1'b1) begin
      n_fail++; $display("FAIL hr_pulse: got %b expected 1", ALERT_ReceivedHardReset);
    end
    tick();
    n_checks++;
    if (ALERT_ReceivedHardReset !== 1'b0) begin
      n_fail++; $display("FAIL hr_pulse_end: got %b expected 0", ALERT_ReceivedHardReset);
    end
    fr = '{8'h43, 8'h14, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(3'd0, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (ALERT_ReceivedSOP_MessageStatus !== 1'b1 || RX_BUF_DATA_OBJECTS[31:0] !== 32'h08070605) begin
      n_fail++; $display("FAIL hr_id_cleared: got alert=%b data=%h expected 1 08070605",
                         ALERT_ReceivedSOP_MessageStatus, RX_BUF_DATA_OBJECTS[31:0]);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_rx();
    PHY_RX_SOP        = 1'b1;
    PHY_RX_FRAME_TYPE = 3'd0;
    tick();
    PHY_RX_SOP   = 1'b0;
    PHY_RX_VALID = 1'b1;
    PHY_RX_DATA  = 8'h43;
    tick();
    PHY_RX_VALID = 1'b0;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (ALERT_ReceivedSOP_MessageStatus !== 1'b0 || RX_BUF_BYTE_COUNT !== 8'd0 ||
        RX_BUF_DATA_OBJECTS !== 224'd0 || RX_BUF_HEADER_BYTE_0 !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: got alert=%b cnt=%0d h0=%h expected 0 0 00",
                         ALERT_ReceivedSOP_MessageStatus, RX_BUF_BYTE_COUNT, RX_BUF_HEADER_BYTE_0);
    end
    tick();
    RESET = 1'b0;
    tick();
    fr = '{8'h43, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(3'd1, fr, 1'b1);
    ticks(2);
    n_checks++;
    if (RX_BUF_FRAME_TYPE !== 8'd1 || RX_BUF_BYTE_COUNT !== 8'd6 ||
        RX_BUF_DATA_OBJECTS[31:0] !== 32'hDDCCBBAA) begin
      n_fail++; $display("FAIL post_reset_rx: got ft=%0d cnt=%0d data=%h expected 1 6 ddccbbaa",
                         RX_BUF_FRAME_TYPE, RX_BUF_BYTE_COUNT, RX_BUF_DATA_OBJECTS[31:0]);
    end
    n_checks++;
    if (TX_GOODCRC_REQUEST !== 1'b1 || TX_GOODCRC_FRAME_TYPE !== 3'd1 ||
        ALERT_ReceivedSOP_MessageStatus !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_req: got req=%b ft=%0d alert=%b expected 1 1 1",
                         TX_GOODCRC_REQUEST, TX_GOODCRC_FRAME_TYPE,
                         ALERT_ReceivedSOP_MessageStatus);
    end
    pulse_ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_goodcrc();
    test_data_msg();
    test_duplicate();
    test_discard();
    test_alert_busy();
    test_hard_reset();
    test_reset_mid_rx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prl_rx.md
# prl_rx

Protocol-layer receive engine for the USB PD port. It sits directly downstream of the PHY receiver and feeds the transmit state machine. It assembles framed bytes from the PHY and validates header, length and MessageID. Accepted messages are stored in the RX buffer registers; the block also raises GoodCRC_Response for the transmitter's MessageID match and requests GoodCRC replies for incoming non-GoodCRC messages.

## Interface
- MAX_BYTES, 30, maximum message length in bytes (2 header + 28 data).
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PHY_RX_SOP  in  1  one-cycle pulse, start of frame.
- PHY_RX_FRAME_TYPE  in  3  frame type, valid with PHY_RX_SOP:
  - 0–4 = SOP family.
  - 6 = Hard Reset.
- PHY_RX_VALID  in  1  PHY_RX_DATA holds a byte this cycle.
- PHY_RX_DATA  in  8  received byte, header low first.
- PHY_RX_EOP  in  1  one-cycle pulse, end of frame.
- PHY_RX_CRC_OK  in  1  CRC verdict, valid with PHY_RX_EOP.
- ALERT_CLEAR  in  1  pulse; clears the receive alert and frees the buffer.
- TX_GOODCRC_ACK  in  1  pulse; transmitter has taken the GoodCRC request.
- RX_BUF_FRAME_TYPE  out  8  frame type of the stored message, zero-extended.
- RX_BUF_HEADER_BYTE_0  out  8  stored header low byte.
- RX_BUF_HEADER_BYTE_1  out  8  stored header high byte.
- RX_BUF_BYTE_COUNT  out  8  stored length including header.
- RX_BUF_DATA_OBJECTS  out  224  data bytes; byte k≥2 sits at bits [8(k-2)+7 : 8(k-2)]; unused bits are 0.
- GoodCRC_Response  out  1  one-cycle pulse: valid GoodCRC stored.
- TX_GOODCRC_REQUEST  out  1  level; held until TX_GOODCRC_ACK.
- TX_GOODCRC_FRAME_TYPE  out  3  frame type to reply on.
- ALERT_ReceivedSOP_MessageStatus  out  1  sticky; set on an accepted message.
- ALERT_ReceivedHardReset  out  1  one-cycle pulse.

All outputs reset to 0.

## Operation
States: WAIT_SOP, RECEIVE, CHECK, STORE, SEND_GOODCRC.

- **WAIT_SOP**
  - PHY_RX_SOP with frame type 6:
    - clear all stored MessageIDs;
    - pulse ALERT_ReceivedHardReset;
    - stay in WAIT_SOP.
  - PHY_RX_SOP with frame type 0–4: latch the frame type, clear the byte counter, go to RECEIVE.
  - Frame types 5 and 7 are ignored.
- **RECEIVE**
  - Each PHY_RX_VALID writes into a staging buffer at the current index, then increments the counter.
  - A byte arriving past MAX_BYTES sets an overflow flag; the byte is dropped.
  - PHY_RX_EOP goes to CHECK.
  - PHY_RX_SOP restarts reception: staging buffer cleared, new frame type latched.
- **CHECK** (one cycle). Field definitions:
  - NDO = header byte 1 [6:4].
  - MessageID = header byte 1 [3:1].
  - MsgType = header byte 0 [4:0].
  - GoodCRC is MsgType 5'b00001 with NDO 0.
- **CHECK outcomes**, in priority order:
  - Discard silently (back to WAIT_SOP) on any of: CRC not OK, overflow, count ≠ 2+4·NDO, or count < 2.
  - GoodCRC: go to STORE.
  - Alert still set: discard with no GoodCRC (buffer busy).
  - MessageID equals the stored ID for the frame type and that ID is valid: duplicate; go to SEND_GOODCRC without storing.
  - Otherwise: go to STORE.
- **STORE** copies the staging buffer to the RX_BUF_* outputs.
  - GoodCRC: pulse GoodCRC_Response, return to WAIT_SOP.
  - Non-GoodCRC:
    - update the stored MessageID for the frame type and set its valid bit;
    - set ALERT_ReceivedSOP_MessageStatus;
    - go to SEND_GOODCRC.
- **SEND_GOODCRC**
  - Assert TX_GOODCRC_REQUEST with TX_GOODCRC_FRAME_TYPE = latched frame type.
  - On TX_GOODCRC_ACK, deassert and go to WAIT_SOP.
  - PHY input is ignored in this state.
- **MessageID table**
  - One 3-bit ID plus a valid bit for each of frame types 0, 1 and 2; types 3 and 4 share entry 0.
  - Cleared by RESET or a Hard Reset frame.
- **Alert clear**: ALERT_CLEAR clears the alert. If it coincides with a set in STORE, the set wins.

## Timing
- RX_BUF_* and GoodCRC_Response update in the STORE cycle, two clocks after the EOP clock edge.
- RX_BUF_* are stable from the GoodCRC_Response pulse onward, so the transmitter can compare them in its following state.
- PHY_RX_VALID and PHY_RX_EOP in the same cycle: the byte is stored first, then the frame ends.
- TX_GOODCRC_REQUEST rises at the STORE→SEND_GOODCRC edge; an ACK in the same cycle the request rises is honoured.
- RESET at any point:
  - FSM returns to WAIT_SOP;
  - buffers, IDs, alerts and request are cleared;
  - no pulses are emitted.

## Structure
- Shared package constants:
  - state encodings;
  - frame-type codes (SOP=0 … Hard Reset=6);
  - GOODCRC_MSGTYPE = 5'b00001;
  - MAX_BYTES.
- One sub-module, prl_rx_msgid_table: three ID entries with valid bits, lookup, update and clear ports.

## Test plan
- SOP type 0, header 0x41/0x00 (GoodCRC, NDO 0, ID 0), CRC OK:
  - GoodCRC_Response pulses two clocks after EOP;
  - RX_BUF_HEADER_BYTE_1 = 0x00;
  - no TX_GOODCRC_REQUEST.
- SOP type 0, header 0x43/0x12 (NDO 1, ID 1), 4 data bytes AA BB CC DD:
  - RX_BUF_BYTE_COUNT = 6;
  - RX_BUF_DATA_OBJECTS[31:0] = 0xDDCCBBAA;
  - alert set;
  - TX_GOODCRC_REQUEST held until ACK.
- Same message repeated after ALERT_CLEAR: duplicate ID; GoodCRC requested, alert stays 0, buffer unchanged.
- Message with CRC_OK = 0, and separately 31 bytes: no output change, FSM back in WAIT_SOP.
- New message while alert still set: discarded, no GoodCRC request. Hard Reset frame: ALERT_ReceivedHardReset pulses and IDs clear, so the previous ID is accepted again.
- RESET asserted mid-RECEIVE: all outputs 0 immediately; the next valid message is received normally.
